// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and types for the instruction-fetch block.
//                NOP_INSTR fills entries that carry a fault. FAULT_* gives the
//                fault cause attached to each queue entry. state_t gives the
//                states of the fetch sequencer. fetch_entry_t is one
//                prefetch-queue entry. is_oob tests a fetch PC against the
//                size of the instruction memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

    localparam int unsigned FAULT_W        = 2;
    localparam logic [1:0]  FAULT_NONE     = 2'b00;
    localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
    localparam logic [1:0]  FAULT_OOB      = 2'b10;

    localparam int unsigned STATE_W        = 2;
    typedef enum logic [STATE_W-1:0] {
        RUN      = 2'd0,
        MISALIGN = 2'd1,
        HALT     = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [31:0]        instr;
        logic [FAULT_W-1:0] fault;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    // The word index is the PC with its byte-offset bits dropped. Any index at
    // or beyond the memory size is out of range.
    function automatic logic is_oob(input logic [31:0] pc, input logic [31:0] mem_words);
        return ({2'b00, pc[31:2]} >= mem_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Circular prefetch FIFO with registered storage. It accepts a
//                push and a pop in the same cycle, has a synchronous flush,
//                and reports its occupancy.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                flush         - empty the queue; a same-cycle push/pop is
//                                dropped
//                push, wdata   - write one entry (the caller ensures there is
//                                space or a same-cycle pop)
//                pop           - retire the head entry
//                rdata         - head entry, read from storage registers
//                count         - number of valid entries
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 66,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_do_push;
    logic             w_do_pop;

    // A flush takes priority over all traffic in the same cycle.
    assign w_do_push = push & ~flush;
    assign w_do_pop  = pop  & ~flush;

    // Storage needs no reset. Validity is tracked by the pointers and the count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction-fetch sequencer. It owns the fetch PC, reads the
//                single-cycle instruction memory, and buffers the fetched
//                words with their PCs in a prefetch queue. Decode takes
//                entries from that queue over a valid/ready handshake. A
//                redirect flushes the queue and restarts fetch at the target.
//                A misaligned redirect target yields one fault entry and then
//                a halt. A fetch beyond the end of memory yields one fault
//                entry and then a halt.
//  Ports       : clk, rst                  - clock, synchronous active-high
//                                            reset
//                imem_addr / imem_rdata    - memory address (= fetch_pc) and
//                                            the data read from it in the
//                                            same cycle
//                redirect_valid/redirect_pc - one-cycle restart request
//                out_valid/out_ready       - head handshake to decode
//                out_instr/out_pc/out_fault - head entry contents
//                fetch_pc                  - current fetch PC (debug)
//                perf_fetched/perf_stall   - counters, present only when
//                                            FETCH_PERF_CNT_EN is defined
//  Config      : FETCH_PERF_CNT_EN - adds the performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2,
    parameter int          MEM_WORDS   = 16384
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [1:0]  out_fault,
    output logic [31:0] fetch_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int          c_CNT_W     = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [31:0] c_MEM_WORDS = 32'(MEM_WORDS);

    state_t              r_state;
    logic [31:0]         r_pc;

    logic [c_CNT_W-1:0]  w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_space;
    logic                w_push_run;
    logic                w_push_mis;
    logic                w_push;
    logic                w_oob;
    fetch_entry_t        w_wr_entry;
    fetch_entry_t        w_head;

    assign w_full  = (w_count == c_CNT_W'(QUEUE_DEPTH));
    assign w_empty = (w_count == '0);
    assign w_pop   = ~w_empty & out_ready;

    // When the queue is full, a pop in the same cycle frees the slot. This
    // keeps throughput at one entry per cycle.
    assign w_space    = ~w_full | w_pop;
    assign w_push_run = (r_state == RUN)      & ~redirect_valid & w_space;
    assign w_push_mis = (r_state == MISALIGN) & ~redirect_valid & w_space;
    assign w_push     = w_push_run | w_push_mis;

    assign w_oob = is_oob(r_pc, c_MEM_WORDS);

    // A faulting entry carries a NOP instead of memory data, so decode never
    // sees garbage from a bad address.
    always_comb begin
        w_wr_entry.pc    = r_pc;
        w_wr_entry.instr = imem_rdata;
        w_wr_entry.fault = FAULT_NONE;
        if (r_state == MISALIGN) begin
            w_wr_entry.instr = NOP_INSTR;
            w_wr_entry.fault = FAULT_MISALIGN;
        end else if (w_oob) begin
            w_wr_entry.instr = NOP_INSTR;
            w_wr_entry.fault = FAULT_OOB;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (w_push),
        .wdata (w_wr_entry),
        .pop   (w_pop),
        .rdata (w_head),
        .count (w_count)
    );

    // Fetch sequencer. A redirect overrides every state. Reset overrides the
    // redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_state <= (redirect_pc[1:0] != 2'b00) ? MISALIGN : RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_push_run) begin
                        r_pc <= r_pc + 32'd4;
                        if (w_oob) begin
                            r_state <= HALT;
                        end
                    end
                end
                MISALIGN: begin
                    // The fault entry is the only output of this state. The
                    // PC stays at the bad target so the debug view shows it.
                    if (w_push_mis) begin
                        r_state <= HALT;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= HALT;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    // A stall is a cycle in which fetch could run but the queue has no slot.
    assign w_stall = (r_state == RUN) & ~redirect_valid & ~w_space;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_push && !redirect_valid) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

    assign imem_addr = r_pc;
    assign fetch_pc  = r_pc;
    assign out_valid = ~w_empty;
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;
    assign out_fault = w_empty ? FAULT_NONE : w_head.fault;

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle-read instruction memory. It owns the fetch PC and drives the word-aligned memory address. It buffers returned words with their PCs in a small prefetch queue and hands them to decode over a valid/ready handshake. Redirects from branch/jump resolution flush the queue and restart fetch.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
QUEUE_DEPTH, 2, prefetch entries; power of 2, >=2
MEM_WORDS, 16384, instruction memory size in 32-bit words; fetches at or beyond this index are flagged out-of-range

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
imem_addr  out  32  byte address to instruction memory; always equals fetch_pc
imem_rdata  in  32  combinational read data for imem_addr, same cycle
redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
redirect_pc  in  32  redirect target
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  32  head instruction word
out_pc  out  32  head PC
out_fault  out  2  head fault cause: 00 none, 01 misaligned, 10 out-of-range
fetch_pc  out  32  current fetch PC (debug)

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC, queue count=0, rd/wr pointers=0, state=RUN. Outputs: out_valid=0, out_fault=00. out_instr/out_pc are don't-care while out_valid=0.
- Queue is a circular FIFO with registered storage. Outputs come from the head entry, so there is no combinational path from imem_rdata to out_*.
- pop = out_valid & out_ready.
- push = state==RUN & !redirect_valid & (count<QUEUE_DEPTH | pop).
- Full queue with a simultaneous pop still pushes, so throughput is 1 instruction/cycle.
- On push, the entry {pc=fetch_pc, instr=imem_rdata, fault} is written and fetch_pc += 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Out-of-range (fetch_pc[31:2] >= MEM_WORDS): entry gets fault=10 and instr=32'h0000_0013. state->HALT; no further pushes.
- Redirect has top priority. At the edge with redirect_valid=1:
  - queue flushed (count=0, pointers reset); any same-cycle pop or push is discarded;
  - fetch_pc=redirect_pc.
- Redirect to a misaligned target (redirect_pc[1:0]!=0):
  - fetch_pc=redirect_pc, state->MISALIGN.
  - In MISALIGN, the next edge pushes one entry {redirect_pc, 32'h0000_0013, fault=01} (if space), then state->HALT.
- HALT: no fetch and no push. The queue drains normally. Only a redirect or rst leaves HALT.
- An aligned redirect in any state -> RUN.
- Latency:
  - reset deassert at edge E: first instruction valid after edge E+1;
  - redirect at edge N: out_valid=0 during N..N+1, target instruction valid after edge N+1.
- Holding out_ready=0 stalls: the queue fills to QUEUE_DEPTH, then fetch_pc freezes and the head stays stable.
- rst mid-operation overrides redirect and push; the queue is emptied.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetched[31:0] (increments per push) and perf_stall[31:0] (increments per cycle where state==RUN, !redirect_valid and push is blocked by a full queue). Both counters clear on rst and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header fetch_pkg: constants NOP_INSTR=32'h0000_0013, fault codes FAULT_NONE/FAULT_MISALIGN/FAULT_OOB, state encodings RUN/MISALIGN/HALT.
- One sub-module: fetch_queue (parameterised FIFO with flush, simultaneous push/pop, count output). fetch_ctrl holds the PC, the FSM and the fault logic.

Test Plan:
- Reset then out_ready=1, memory words i at addr 4i -> out_pc 0,4,8,… with out_instr matching, one per cycle after first valid, out_fault=00.
- out_ready=0 for 5 cycles after reset -> count saturates at 2, fetch_pc holds at 8, head stays pc=0; release -> pc 0,4,8 delivered in order with no gaps.
- Redirect to 32'h100 while full and popping -> out_valid=0 next cycle, next delivered out_pc=32'h100, no stale 0/4 entries.
- Redirect to 32'h102 -> one entry {pc=32'h102, instr=32'h13, fault=01}, then no more valids; later redirect to 32'h200 resumes at 32'h200.
- Fetch reaching word index MEM_WORDS (addr 32'h0001_0000, default MEM_WORDS) -> entry fault=10, instr=32'h13, then HALT.
- rst asserted mid-stream with redirect_valid=1 -> after edge out_valid=0, fetch_pc=RESET_PC; with FETCH_PERF_CNT_EN, both counters read 0.
